// File: rtl/fp16_norm_arbiter.sv
// fp16_norm_arbiter: round-robin share of one FP16 normalizer between NREQ
// arithmetic front ends, wrapped in a two-stage valid/ready pipeline.

package fp16Pkg;
    // Expanded operand from the arithmetic cores. Binary point sits between
    // sig[12] and sig[11]; sig[13] is a carry-out bit, sig[1:0] are extra
    // precision below the 10-bit fraction. exp is biased (bias 15), unclamped.
    typedef struct packed {
        logic        sign;
        logic [6:0]  exp;
        logic [13:0] sig;
    } FP16X;

    // Normalized result handed to the rounding unit: fp16 fields plus
    // guard and sticky bits.
    typedef struct packed {
        logic        sign;
        logic [4:0]  exp;
        logic [9:0]  frac;
        logic [1:0]  grs;
    } FP16N;

    localparam int XW = $bits(FP16X);
    localparam int NW = $bits(FP16N);
endpackage

// Combinational normalizer: moves the leading one to sig[12], adjusts the
// exponent, flushes results below the normal range and saturates overflow
// to infinity.
module fpNormalize16Combo (
    input  fp16Pkg::FP16X x_i,
    input  logic          under_i,
    output fp16Pkg::FP16N o,
    output logic          under_o,
    output logic          inexact_o
);
    logic [3:0]        w_lz;
    logic [12:0]       w_m;
    logic              w_st;
    logic signed [8:0] w_ne;

    // leading-zero count of sig[12:0]; the highest set bit wins
    always_comb begin
        w_lz = 4'd0;
        for (int i = 0; i <= 12; i++)
            if (x_i.sig[i]) w_lz = 4'(12 - i);
    end

    // align mantissa so the leading one lands on bit 12, track exponent
    always_comb begin
        if (x_i.sig[13]) begin
            w_m  = x_i.sig[13:1];
            w_st = x_i.sig[0];
            w_ne = $signed({2'b00, x_i.exp}) + 9'sd1;
        end else begin
            w_m  = x_i.sig[12:0] << w_lz;
            w_st = 1'b0;
            w_ne = $signed({2'b00, x_i.exp}) - $signed({5'b00000, w_lz});
        end
    end

    // classify: zero (no leading one), flush, overflow, normal
    always_comb begin
        o         = '0;
        o.sign    = x_i.sign;
        under_o   = under_i;
        inexact_o = 1'b0;
        if (!w_m[12]) begin
            // exact signed zero
        end else if (w_ne <= 9'sd0) begin
            under_o   = 1'b1;
            inexact_o = 1'b1;
        end else if (w_ne >= 9'sd31) begin
            o.exp     = 5'd31;
            inexact_o = 1'b1;
        end else begin
            o.exp     = w_ne[4:0];
            o.frac    = w_m[11:2];
            o.grs     = {w_m[1], w_m[0] | w_st};
            inexact_o = w_m[1] | w_m[0] | w_st;
        end
    end
endmodule

module fp16_norm_arbiter #(
    parameter  int NREQ = 4,
    parameter  int TAGW = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ce,
    input  logic [NREQ-1:0]                    req_valid,
    output logic [NREQ-1:0]                    req_ready,
    input  logic [NREQ-1:0][fp16Pkg::XW-1:0]   req_x,
    input  logic [NREQ-1:0]                    req_under,
    input  logic [NREQ-1:0][TAGW-1:0]          req_tag,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [fp16Pkg::NW-1:0]             out_o,
    output logic                               out_under,
    output logic                               out_inexact,
    output logic [IDW-1:0]                     out_id,
    output logic [TAGW-1:0]                    out_tag,
    output logic                               busy
);
    // S1 state
    logic                r_v1;
    fp16Pkg::FP16X       r_x1;
    logic                r_under1;
    logic [IDW-1:0]      r_id1;
    logic [TAGW-1:0]     r_tag1;
    // S2 state
    logic                r_v2;
    fp16Pkg::FP16N       r_o2;
    logic                r_under2;
    logic                r_inexact2;
    logic [IDW-1:0]      r_id2;
    logic [TAGW-1:0]     r_tag2;
    // arbitration
    logic [IDW-1:0]      r_last;
    logic                w_any;
    logic [IDW-1:0]      w_cand;
    logic                w_adv1;
    logic                w_adv2;
    logic                w_take;
    fp16Pkg::FP16N       w_norm_o;
    logic                w_norm_under;
    logic                w_norm_inexact;

    // (last + k) mod NREQ without a divider; last + k < 2*NREQ always
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] last, input int k);
        int s;
        s = int'(last) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    assign w_adv2 = ce & r_v1 & (~r_v2 | out_ready);
    assign w_adv1 = ce & (~r_v1 | w_adv2);
    // rst_n gate keeps req_ready quiet while reset is held
    assign w_take = w_adv1 & w_any & rst_n;

    // round-robin search starting just after the last winner; iterating from
    // the far end lets the nearest valid requester overwrite the others
    always_comb begin
        w_any  = 1'b0;
        w_cand = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[rr_idx(r_last, k)]) begin
                w_any  = 1'b1;
                w_cand = rr_idx(r_last, k);
            end
        end
    end

    // one-hot grant to the candidate when S1 can take a new operand
    always_comb begin
        req_ready = '0;
        if (w_take) req_ready[w_cand] = 1'b1;
    end

    fpNormalize16Combo u_norm (
        .x_i       (r_x1),
        .under_i   (r_under1),
        .o         (w_norm_o),
        .under_o   (w_norm_under),
        .inexact_o (w_norm_inexact)
    );

    // S1: capture the winning request, advance the round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_x1     <= '0;
            r_under1 <= 1'b0;
            r_id1    <= '0;
            r_tag1   <= '0;
            r_last   <= IDW'(NREQ - 1);
        end else if (w_adv1) begin
            r_v1 <= w_any;
            if (w_any) begin
                r_x1     <= req_x[w_cand];
                r_under1 <= req_under[w_cand];
                r_id1    <= w_cand;
                r_tag1   <= req_tag[w_cand];
                r_last   <= w_cand;
            end
        end
    end

    // S2: register normalizer results; hold while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2       <= 1'b0;
            r_o2       <= '0;
            r_under2   <= 1'b0;
            r_inexact2 <= 1'b0;
            r_id2      <= '0;
            r_tag2     <= '0;
        end else if (ce) begin
            if (w_adv2) begin
                r_v2       <= 1'b1;
                r_o2       <= w_norm_o;
                r_under2   <= w_norm_under;
                r_inexact2 <= w_norm_inexact;
                r_id2      <= r_id1;
                r_tag2     <= r_tag1;
            end else if (out_ready) begin
                r_v2 <= 1'b0;
            end
        end
    end

    assign out_valid   = r_v2;
    assign out_o       = r_o2;
    assign out_under   = r_under2;
    assign out_inexact = r_inexact2;
    assign out_id      = r_id2;
    assign out_tag     = r_tag2;
    assign busy        = r_v1 | r_v2;
endmodule

// File: tb/tb_fp16_norm_arbiter.sv
// Self-checking bench for fp16_norm_arbiter: arithmetic normalizer model,
// cycle model of grants/occupancy, FIFO scoreboard for results.
module tb_fp16_norm_arbiter;
    localparam int NREQ = 4;
    localparam int TAGW = 4;
    localparam int XW   = fp16Pkg::XW;
    localparam int NW   = fp16Pkg::NW;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          ce;
    logic [NREQ-1:0]               req_valid;
    logic [NREQ-1:0]               req_ready;
    logic [NREQ-1:0][XW-1:0]       req_x;
    logic [NREQ-1:0]               req_under;
    logic [NREQ-1:0][TAGW-1:0]     req_tag;
    logic                          out_valid;
    logic                          out_ready;
    logic [NW-1:0]                 out_o;
    logic                          out_under;
    logic                          out_inexact;
    logic [1:0]                    out_id;
    logic [TAGW-1:0]               out_tag;
    logic                          busy;

    fp16_norm_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
        .req_under(req_under), .req_tag(req_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_o(out_o),
        .out_under(out_under), .out_inexact(out_inexact),
        .out_id(out_id), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             id;
        logic [TAGW-1:0] tag;
        logic [NW-1:0]  o;
        logic           uo;
        logic           ix;
    } item_t;

    int          n_chk = 0;
    int          n_pass = 0;
    item_t       exp_q[$];
    int          grants[$];
    int          outs[$];
    bit          m_v1, m_v2;
    int          m_last;
    logic [NREQ-1:0] acc;
    logic [NREQ-1:0] last_ready;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    // Value-level normalizer: locate the MSB arithmetically, scale the
    // significand to [2^12, 2^13), apply range rules.
    function automatic void norm_model(input logic [XW-1:0] x, input logic ui,
                                       output logic [NW-1:0] o, output logic uo, output logic ix);
        int e, s, p, ne, mant;
        bit lost;
        e  = int'(x[20:14]);
        s  = int'(x[13:0]);
        o  = {x[21], 17'd0};
        uo = ui;
        ix = 1'b0;
        if (s == 0) return;
        p = 0;
        for (int b = 0; b < 14; b++) if (s >= (1 << b)) p = b;
        ne = e + p - 12;
        if (p > 12) begin
            mant = s >> (p - 12);
            lost = (s % (1 << (p - 12))) != 0;
        end else begin
            mant = s << (12 - p);
            lost = 1'b0;
        end
        if (ne <= 0) begin
            uo = 1'b1;
            ix = 1'b1;
        end else if (ne >= 31) begin
            o[16:12] = 5'd31;
            ix = 1'b1;
        end else begin
            o[16:12] = 5'(ne);
            o[11:2]  = 10'((mant >> 2) % 1024);
            o[1]     = 1'((mant >> 1) % 2);
            o[0]     = 1'(mant % 2) | lost;
            ix       = o[1] | o[0];
        end
    endfunction

    task automatic new_req(input int i);
        logic [13:0] s;
        logic [6:0]  e;
        s = 14'($urandom) >> ($urandom % 14);
        if ($urandom % 16 == 0) s = 14'd0;
        e = ($urandom % 8 == 0) ? 7'($urandom) : 7'($urandom_range(0, 35));
        req_x[i]     = {1'($urandom), e, s};
        req_under[i] = 1'($urandom);
        req_tag[i]   = 4'($urandom);
        req_valid[i] = 1'b1;
    endtask

    // One clock: compare everything at the negedge, advance the model,
    // return #1 after the next posedge with inputs free to change.
    task automatic step();
        bit    adv1, adv2, any;
        int    cand, idx;
        item_t it;
        acc = '0;
        @(negedge clk);
        adv2 = ce && m_v1 && (!m_v2 || out_ready);
        adv1 = ce && (!m_v1 || adv2);
        any  = 1'b0;
        cand = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (m_last + k) % NREQ;
            if (!any && req_valid[idx]) begin
                any  = 1'b1;
                cand = idx;
            end
        end
        last_ready = req_ready;
        chk("req_ready", 32'(req_ready), (any && adv1) ? 32'(1 << cand) : 32'd0);
        chk("busy", 32'(busy), 32'(m_v1 || m_v2));
        chk("out_valid", 32'(out_valid), 32'(m_v2));
        if (m_v2) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL scoreboard: result present with no accepted request");
            end else begin
                chk("out_o", 32'(out_o), 32'(exp_q[0].o));
                chk("out_under", 32'(out_under), 32'(exp_q[0].uo));
                chk("out_inexact", 32'(out_inexact), 32'(exp_q[0].ix));
                chk("out_id", 32'(out_id), 32'(exp_q[0].id));
                chk("out_tag", 32'(out_tag), 32'(exp_q[0].tag));
            end
        end
        if (ce && m_v2 && out_ready) begin
            outs.push_back(int'(out_id));
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (ce) m_v2 = adv2 ? 1'b1 : (out_ready ? 1'b0 : m_v2);
        if (adv1) m_v1 = any;
        if (any && adv1) begin
            it.id  = cand;
            it.tag = req_tag[cand];
            norm_model(req_x[cand], req_under[cand], it.o, it.uo, it.ix);
            exp_q.push_back(it);
            grants.push_back(cand);
            m_last = cand;
            acc[cand] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_v1 = 1'b0;
        m_v2 = 1'b0;
        m_last = NREQ - 1;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        grants.delete();
        outs.delete();
    endtask

    task automatic rerequest(input int upto);
        for (int i = 0; i < upto; i++) if (acc[i]) new_req(i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NW-1:0] po;
        logic          pu, pi;
        int            gsave, n0, cyc;

        rst_n = 1'b0; ce = 1'b1; out_ready = 1'b1;
        req_valid = '1; req_x = '0; req_under = '0; req_tag = '0;
        model_reset();

        // hand-computed values pin the normalizer model
        norm_model({1'b1, 7'd0, 14'd0}, 1'b0, po, pu, pi);
        chk("pin_zero_o", 32'(po), 32'h20000); chk("pin_zero_ix", 32'(pi), 32'd0);
        norm_model({1'b0, 7'd15, 14'h1000}, 1'b0, po, pu, pi);
        chk("pin_one_o", 32'(po), 32'h0F000); chk("pin_one_ix", 32'(pi), 32'd0);
        norm_model({1'b0, 7'd15, 14'h2001}, 1'b0, po, pu, pi);
        chk("pin_carry_o", 32'(po), 32'h10001); chk("pin_carry_ix", 32'(pi), 32'd1);
        norm_model({1'b0, 7'd15, 14'h0001}, 1'b0, po, pu, pi);
        chk("pin_shift_o", 32'(po), 32'h03000);
        norm_model({1'b0, 7'd15, 14'h1003}, 1'b0, po, pu, pi);
        chk("pin_grs_o", 32'(po), 32'h0F003); chk("pin_grs_ix", 32'(pi), 32'd1);
        norm_model({1'b0, 7'd5, 14'h0001}, 1'b0, po, pu, pi);
        chk("pin_flush_o", 32'(po), 32'd0); chk("pin_flush_u", 32'(pu), 32'd1);
        norm_model({1'b0, 7'd31, 14'h1000}, 1'b0, po, pu, pi);
        chk("pin_inf_o", 32'(po), 32'h1F000); chk("pin_inf_ix", 32'(pi), 32'd1);

        // reset state with requests asserted: no grant may leak
        #12;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_o", 32'(out_o), 32'd0);
        chk("rst_flags", 32'({out_under, out_inexact}), 32'd0);
        chk("rst_id_tag", 32'({out_id, out_tag}), 32'd0);
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single request from requester 2
        req_x[2] = {1'b1, 7'd0, 14'd0}; req_tag[2] = 4'd5; req_under[2] = 1'b0; req_valid[2] = 1'b1;
        step();
        chk("t1_ready", 32'(last_ready), 32'h4);
        req_valid[2] = 1'b0;
        step();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_id", 32'(out_id), 32'd2);
        chk("t1_tag", 32'(out_tag), 32'd5);
        chk("t1_o", 32'(out_o), 32'h20000);
        chk("t1_inexact", 32'(out_inexact), 32'd0);
        repeat (2) step();

        // fair sharing, full throughput
        do_reset();
        for (int i = 0; i < NREQ; i++) new_req(i);
        repeat (8) begin step(); rerequest(NREQ); end
        chk("t2_accepts", 32'(grants.size()), 32'd8);
        for (int k = 0; k < 8 && k < grants.size(); k++) chk("t2_grant", 32'(grants[k]), 32'(k % 4));
        req_valid = '0;
        repeat (3) step();
        chk("t2_results", 32'(outs.size()), 32'd8);
        for (int k = 0; k < 8 && k < outs.size(); k++) chk("t2_out_id", 32'(outs[k]), 32'(k % 4));

        // backpressure: only two operands fit
        do_reset();
        out_ready = 1'b0;
        new_req(0); new_req(1);
        repeat (5) begin step(); rerequest(2); end
        chk("t3_accepts", 32'(grants.size()), 32'd2);
        chk("t3_blocked", 32'(last_ready), 32'd0);
        out_ready = 1'b1; req_valid = '0;
        repeat (4) step();
        chk("t3_results", 32'(outs.size()), 32'd2);
        if (outs.size() == 2) begin
            chk("t3_order0", 32'(outs[0]), 32'd0);
            chk("t3_order1", 32'(outs[1]), 32'd1);
        end

        // reset with both stages full
        for (int i = 0; i < NREQ; i++) new_req(i);
        repeat (4) begin step(); rerequest(NREQ); end
        chk("t5_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("t5_ready_edge", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        model_reset();
        grants.delete(); outs.delete();
        step();
        chk("t5_first_grant", (grants.size() > 0) ? 32'(grants[0]) : 32'd99, 32'd0);
        rerequest(NREQ);

        // clock-enable gating mid-stream
        repeat (3) begin step(); rerequest(NREQ); end
        gsave = grants.size();
        ce = 1'b0;
        repeat (3) begin step(); chk("t6_ready_low", 32'(last_ready), 32'd0); end
        chk("t6_no_accept", 32'(grants.size()), 32'(gsave));
        ce = 1'b1;
        repeat (3) begin step(); rerequest(NREQ); end
        chk("t6_resume", 32'(grants.size()), 32'(gsave + 3));

        // randomized datapath and handshake soak
        n0 = grants.size();
        cyc = 0;
        while (grants.size() - n0 < 1000 && cyc < 20000) begin
            out_ready = ($urandom % 4 != 0);
            ce        = ($urandom % 10 != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    if ($urandom % 4 != 0) new_req(i);
                    else req_valid[i] = 1'b0;
                end else if ($urandom % 20 == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            step();
            cyc++;
        end
        chk("t4_accepts", 32'(grants.size() - n0 >= 1000), 32'd1);
        ce = 1'b1; out_ready = 1'b1; req_valid = '0;
        repeat (4) step();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fp16_norm_arbiter.md
# fp16_norm_arbiter

Shares a single `fpNormalize16Combo` normalization datapath among NREQ half-precision arithmetic units (add, mul, div, fma front ends). The block arbitrates round-robin among requesters and wraps the combinational normalizer in a two-stage valid/ready pipeline. Each result carries the winner's ID and a caller tag back to a shared result bus. It sits between the FP16 arithmetic cores and the rounding unit.

## Interface

Parameters:
- NREQ, 4: number of requesters (2..8).
- TAGW, 4: width of the opaque per-operation tag.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ce  in  1  clock enable; low freezes all state and blocks handshakes.
- req_valid  in  NREQ  request present, one bit per requester.
- req_ready  out  NREQ  request accepted this cycle, one-hot or zero.
- req_x  in  NREQ×$bits(FP16X)  expanded-format operand per requester (fp16Pkg::FP16X).
- req_under  in  NREQ  underflow flag per requester.
- req_tag  in  NREQ×TAGW  tag per requester.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_o  out  $bits(FP16N)  normalized result (fp16Pkg::FP16N).
- out_under  out  1  normalizer under_o.
- out_inexact  out  1  normalizer inexact_o.
- out_id  out  $clog2(NREQ)  index of the originating requester.
- out_tag  out  TAGW  tag of the originating request.
- busy  out  1  any pipeline stage occupied.

## Operation

- **Stage S1 (input register).** Holds v1, x1, under1, id1 and tag1. S1 drives a single internal `fpNormalize16Combo` instance.
- **Stage S2 (output register).** Holds v2 and captures the normalizer outputs o, under_o and inexact_o, plus id and tag from S1.
- **Transfer conditions.**
  - adv2 = ce & v1 & (!v2 | out_ready).
  - adv1 = ce & (!v1 | adv2).
- **Arbitration.**
  - Round-robin pointer `last` (reset NREQ-1).
  - Candidate = first i with req_valid[i], scanning last+1, last+2, … modulo NREQ.
  - req_ready[candidate] = adv1. All other req_ready bits are 0.
  - `last` updates to the candidate only when a handshake completes (req_valid & req_ready).
- **No valid requests.** req_ready = 0; if adv1, v1 clears.
- **Requester obligations.** Requesters hold req_x, req_under and req_tag stable while req_valid is high and unaccepted. The arbiter does not require them to hold valid; withdrawal is permitted.
- **Flag decoding.** out_under and out_inexact are exactly the normalizer outputs for the captured operand. The block does not reinterpret them.
- **busy** = v1 | v2.
- **ce low.** No register changes, req_ready = 0, and outputs hold their values.

## Timing

- **Reset values.** On rst_n low (asynchronous): v1 = v2 = 0, last = NREQ-1, and out_o, out_under, out_inexact, out_id, out_tag, x1, id1, tag1 all 0. Consequently out_valid = 0, req_ready = 0 and busy = 0.
- **Latency.** Accept at edge k; out_valid is high after edge k+1. Latency is 2 edges from acceptance to the result being visible with out_ready continuously high.
- **Throughput.** One result per cycle when out_ready is high and requests are continuous.
- **Backpressure.**
  - out_valid and all out_* hold stable while out_ready is low.
  - With S2 full and out_ready low, S1 can still fill once. After that, req_ready = 0 until out_ready.
  - No result is ever dropped or duplicated.
- **Simultaneous out_ready and new accept.** The pipeline shifts both stages in the same edge.
- **Pointer wrap.** After requester NREQ-1 is granted, requester 0 is searched first.
- **Non-power-of-two NREQ.** The modulo wraps correctly; out_id never exceeds NREQ-1.
- **Reset mid-operation.** In-flight results are discarded. No req_ready pulse occurs during reset.

## Test plan

1. **Single request.**
   - Stimulus: requester 2 issues one request with req_x = 0 and sign 1, tag 5; out_ready = 1.
   - Expected: req_ready = 4'b0100 for one cycle. After 2 edges, out_valid = 1 with out_id = 2, out_tag = 5, out_o.sign = 1, exponent and significand 0, out_inexact = 0.
2. **Fair sharing.**
   - Stimulus: all 4 requesters assert req_valid continuously for 8 accepts; out_ready = 1.
   - Expected: grant order 0,1,2,3,0,1,2,3; one result per cycle; out_id follows the same order.
3. **Backpressure.**
   - Stimulus: hold out_ready = 0 for 5 cycles while requesters 0 and 1 stream requests.
   - Expected: exactly 2 accepts, then req_ready = 0. out_* remain stable throughout. After release, results arrive in order with no loss.
4. **Datapath equivalence.**
   - Stimulus: 1000 random FP16X operands with random under flags.
   - Expected: out_o, out_under and out_inexact bit-match a standalone normalizer model; IDs and tags match.
5. **Reset mid-stream.**
   - Stimulus: assert rst_n = 0 asynchronously with v1 = v2 = 1.
   - Expected: out_valid = 0 and busy = 0 immediately. After release, the first grant goes to requester 0.
6. **ce gating.**
   - Stimulus: ce = 0 for 3 cycles mid-stream.
   - Expected: req_ready = 0, all outputs frozen; stream resumes unchanged when ce returns to 1.
